// File: rtl/pwm_int_core.sv
// PWM generator with double-buffered period/duty, period-end pulse and
// sticky pending/overflow interrupt flags for the PWM_w_Int register slave.
module pwm_int_core #(
    parameter int unsigned C_CNT_WIDTH = 32
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic                   ctrl_en,
    input  logic                   ctrl_int_en,
    input  logic [C_CNT_WIDTH-1:0] ctrl_period,
    input  logic [C_CNT_WIDTH-1:0] ctrl_duty,
    input  logic                   int_clr,
    output logic                   pwm_out,
    output logic                   irq,
    output logic                   period_end,
    output logic [C_CNT_WIDTH-1:0] cnt_value,
    output logic [2:0]             status
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_t;

    localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = C_CNT_WIDTH'(1);

    state_t                 state;
    logic [C_CNT_WIDTH-1:0] cnt;
    logic [C_CNT_WIDTH-1:0] sh_period;
    logic [C_CNT_WIDTH-1:0] sh_duty;
    logic                   pwm_q;
    logic                   int_pend;
    logic                   int_ovf;
    logic                   at_end;
    logic [C_CNT_WIDTH-1:0] cnt_inc;
    logic                   reload_ok;

    assign at_end    = (state != IDLE) && (cnt == sh_period - CNT_ONE);
    assign cnt_inc   = cnt + CNT_ONE;
    assign reload_ok = ctrl_en && (ctrl_period != '0);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= IDLE;
            cnt       <= '0;
            sh_period <= '0;
            sh_duty   <= '0;
            pwm_q     <= 1'b0;
            int_pend  <= 1'b0;
            int_ovf   <= 1'b0;
        end else begin
            // A period end in the same cycle as int_clr keeps the flags set.
            int_pend <= at_end | (int_pend & ~int_clr);
            int_ovf  <= (at_end & int_pend) | (int_ovf & ~int_clr);

            case (state)
                IDLE: begin
                    cnt   <= '0;
                    pwm_q <= 1'b0;
                    if (reload_ok) begin
                        state     <= RUN;
                        sh_period <= ctrl_period;
                        sh_duty   <= ctrl_duty;
                        pwm_q     <= (ctrl_duty != '0);
                    end
                end
                RUN: begin
                    if (at_end) begin
                        cnt <= '0;
                        // Enable dropping on the last cycle ends the run right here.
                        if (reload_ok) begin
                            sh_period <= ctrl_period;
                            sh_duty   <= ctrl_duty;
                            pwm_q     <= (ctrl_duty != '0);
                        end else begin
                            state <= IDLE;
                            pwm_q <= 1'b0;
                        end
                    end else begin
                        cnt   <= cnt_inc;
                        pwm_q <= (cnt_inc < sh_duty);
                        if (!ctrl_en) begin
                            state <= STOPPING;
                        end
                    end
                end
                STOPPING: begin
                    if (at_end) begin
                        state <= IDLE;
                        cnt   <= '0;
                        pwm_q <= 1'b0;
                    end else begin
                        cnt   <= cnt_inc;
                        pwm_q <= (cnt_inc < sh_duty);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    pwm_q <= 1'b0;
                end
            endcase
        end
    end

    assign pwm_out    = pwm_q;
    assign irq        = int_pend & ctrl_int_en;
    assign period_end = at_end;
    assign cnt_value  = cnt;
    assign status     = {int_ovf, int_pend, (state != IDLE)};

endmodule

// File: tb/tb_pwm_int_core.sv
// Self-checking bench for pwm_int_core: table-driven steady-state runs plus
// hand-written sequences for reload, interrupt, stop and reset corner cases.
module tb_pwm_int_core;

    logic        tb_ACLK = 1'b0;
    logic        tb_ARESET;
    logic        ctrl_en;
    logic        ctrl_int_en;
    logic [31:0] ctrl_period;
    logic [31:0] ctrl_duty;
    logic        int_clr;
    logic        pwm_out;
    logic        irq;
    logic        period_end;
    logic [31:0] cnt_value;
    logic [2:0]  status;

    pwm_int_core #(.C_CNT_WIDTH(32)) dut (
        .ACLK        (tb_ACLK),
        .ARESET      (tb_ARESET),
        .ctrl_en     (ctrl_en),
        .ctrl_int_en (ctrl_int_en),
        .ctrl_period (ctrl_period),
        .ctrl_duty   (ctrl_duty),
        .int_clr     (int_clr),
        .pwm_out     (pwm_out),
        .irq         (irq),
        .period_end  (period_end),
        .cnt_value   (cnt_value),
        .status      (status)
    );

    always #5 tb_ACLK = ~tb_ACLK;

    typedef struct {
        logic        pwm;
        logic [31:0] cnt;
        logic        pe;
        logic [2:0]  st;
        logic        irq;
    } exp_t;

    typedef struct {
        logic [31:0] period;
        logic [31:0] duty;
        int unsigned cycles;
        logic [31:0] exp_high;
        int unsigned exp_pe;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[7];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    string       phase    = "init";

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s/%s cyc=%0d: got %0h expected %0h", phase, name, cyc, act, exp);
        end
    endtask

    // Push the expected post-edge outputs, advance one clock, pop and compare.
    task automatic cycle(input logic e_pwm, input logic [31:0] e_cnt, input logic e_pe,
                         input logic [2:0] e_st, input logic e_irq);
        exp_t e;
        sb.push_back('{pwm: e_pwm, cnt: e_cnt, pe: e_pe, st: e_st, irq: e_irq});
        @(posedge tb_ACLK);
        @(negedge tb_ACLK);
        cyc++;
        e = sb.pop_front();
        chk("pwm_out",    {31'd0, pwm_out},    {31'd0, e.pwm});
        chk("cnt_value",  cnt_value,           e.cnt);
        chk("period_end", {31'd0, period_end}, {31'd0, e.pe});
        chk("status",     {29'd0, status},     {29'd0, e.st});
        chk("irq",        {31'd0, irq},        {31'd0, e.irq});
    endtask

    task automatic do_reset();
        tb_ARESET   = 1'b1;
        ctrl_en     = 1'b0;
        int_clr     = 1'b0;
        ctrl_int_en = 1'b0;
        cycle(1'b0, 32'd0, 1'b0, 3'b000, 1'b0);
        tb_ARESET = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] ph;
        logic [2:0]  st;
        int unsigned pe_seen;

        vecs[0] = '{period: 32'd10, duty: 32'd3,          cycles: 30, exp_high: 32'd3,  exp_pe: 3};
        vecs[1] = '{period: 32'd10, duty: 32'd0,          cycles: 20, exp_high: 32'd0,  exp_pe: 2};
        vecs[2] = '{period: 32'd10, duty: 32'd10,         cycles: 20, exp_high: 32'd10, exp_pe: 2};
        vecs[3] = '{period: 32'd1,  duty: 32'd1,          cycles: 5,  exp_high: 32'd1,  exp_pe: 5};
        vecs[4] = '{period: 32'd4,  duty: 32'd7,          cycles: 12, exp_high: 32'd4,  exp_pe: 3};
        vecs[5] = '{period: 32'd5,  duty: 32'd2,          cycles: 15, exp_high: 32'd2,  exp_pe: 3};
        vecs[6] = '{period: 32'd3,  duty: 32'hFFFF_FFFF,  cycles: 9,  exp_high: 32'd3,  exp_pe: 3};

        tb_ARESET   = 1'b1;
        ctrl_en     = 1'b0;
        ctrl_int_en = 1'b0;
        ctrl_period = 32'd0;
        ctrl_duty   = 32'd0;
        int_clr     = 1'b0;

        phase = "reset";
        do_reset();

        // Steady-state PWM for each table entry, starting from a fresh reset.
        for (int v = 0; v < 7; v++) begin
            phase = $sformatf("vec%0d", v);
            do_reset();
            ctrl_period = vecs[v].period;
            ctrl_duty   = vecs[v].duty;
            ctrl_en     = 1'b1;
            pe_seen     = 0;
            for (int unsigned i = 0; i < vecs[v].cycles; i++) begin
                ph = i % vecs[v].period;
                st = {(i / vecs[v].period) >= 2, (i / vecs[v].period) >= 1, 1'b1};
                cycle(ph < vecs[v].exp_high, ph, ph == vecs[v].period - 1, st, 1'b0);
                if (period_end) pe_seen++;
            end
            chk("pe_count", pe_seen, vecs[v].exp_pe);
        end

        // Mid-period writes only land at the boundary.
        phase = "update";
        do_reset();
        ctrl_period = 32'd10;
        ctrl_duty   = 32'd3;
        ctrl_en     = 1'b1;
        for (int unsigned i = 0; i < 10; i++) begin
            if (i == 6) ctrl_duty = 32'd7;
            if (i == 8) ctrl_period = 32'd4;
            cycle(i < 3, i, i == 9, 3'b001, 1'b0);
        end
        for (int unsigned i = 0; i < 4; i++) begin
            cycle(1'b1, i, i == 3, 3'b011, 1'b0);
        end
        cycle(1'b1, 32'd0, 1'b0, 3'b111, 1'b0);

        // Interrupt flags, clear, and clear colliding with period end.
        phase = "irq";
        do_reset();
        ctrl_int_en = 1'b1;
        ctrl_period = 32'd3;
        ctrl_duty   = 32'd1;
        ctrl_en     = 1'b1;
        cycle(1'b1, 32'd0, 1'b0, 3'b001, 1'b0);
        cycle(1'b0, 32'd1, 1'b0, 3'b001, 1'b0);
        cycle(1'b0, 32'd2, 1'b1, 3'b001, 1'b0);
        cycle(1'b1, 32'd0, 1'b0, 3'b011, 1'b1);
        cycle(1'b0, 32'd1, 1'b0, 3'b011, 1'b1);
        cycle(1'b0, 32'd2, 1'b1, 3'b011, 1'b1);
        cycle(1'b1, 32'd0, 1'b0, 3'b111, 1'b1);
        int_clr = 1'b1;
        cycle(1'b0, 32'd1, 1'b0, 3'b001, 1'b0);
        int_clr = 1'b0;
        cycle(1'b0, 32'd2, 1'b1, 3'b001, 1'b0);
        int_clr = 1'b1;
        cycle(1'b1, 32'd0, 1'b0, 3'b011, 1'b1);
        int_clr     = 1'b0;
        ctrl_int_en = 1'b0;
        #1;
        chk("irq_gated", {31'd0, irq}, 32'd0);
        cycle(1'b0, 32'd1, 1'b0, 3'b011, 1'b0);

        // Dropping enable mid-period lets the period finish, then idles.
        phase = "stop_en";
        do_reset();
        ctrl_period = 32'd10;
        ctrl_duty   = 32'd3;
        ctrl_en     = 1'b1;
        for (int unsigned i = 0; i < 10; i++) begin
            if (i == 5) ctrl_en = 1'b0;
            cycle(i < 3, i, i == 9, 3'b001, 1'b0);
        end
        cycle(1'b0, 32'd0, 1'b0, 3'b010, 1'b0);
        cycle(1'b0, 32'd0, 1'b0, 3'b010, 1'b0);

        // A zero period at the boundary acts as a stop.
        phase = "stop_p0";
        do_reset();
        ctrl_period = 32'd10;
        ctrl_duty   = 32'd3;
        ctrl_en     = 1'b1;
        for (int unsigned i = 0; i < 10; i++) begin
            if (i == 5) ctrl_period = 32'd0;
            cycle(i < 3, i, i == 9, 3'b001, 1'b0);
        end
        cycle(1'b0, 32'd0, 1'b0, 3'b010, 1'b0);
        cycle(1'b0, 32'd0, 1'b0, 3'b010, 1'b0);

        // Reset mid-run drops pending interrupt; restart on the first edge after.
        phase = "reset_mid";
        do_reset();
        ctrl_int_en = 1'b1;
        ctrl_period = 32'd10;
        ctrl_duty   = 32'd3;
        ctrl_en     = 1'b1;
        for (int unsigned i = 0; i < 17; i++) begin
            cycle((i % 10) < 3, i % 10, (i % 10) == 9,
                  (i >= 10) ? 3'b011 : 3'b001, i >= 10);
        end
        tb_ARESET = 1'b1;
        cycle(1'b0, 32'd0, 1'b0, 3'b000, 1'b0);
        tb_ARESET = 1'b0;
        cycle(1'b1, 32'd0, 1'b0, 3'b001, 1'b0);
        cycle(1'b1, 32'd1, 1'b0, 3'b001, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_int_core.md
# pwm_int_core

PWM generation core with period-end interrupt. It sits directly downstream of the PWM_w_Int AXI4-Lite register slave, which supplies period, duty, enable and interrupt-control values. The core produces the PWM output, a level interrupt to the PS, and status fields that the slave returns on register reads. Period and duty are double-buffered, so software writes take effect only on period boundaries and never produce a glitched cycle.

## Interface
- C_CNT_WIDTH, 32, width of counter, period and duty values
- ACLK  in  1  sole clock; all logic is on the rising edge
- ARESET  in  1  reset, synchronous and active-high
- ctrl_en  in  1  run request (slv_reg0[0])
- ctrl_int_en  in  1  interrupt output enable (slv_reg0[1])
- ctrl_period  in  C_CNT_WIDTH  period in ACLK cycles (slv_reg1)
- ctrl_duty  in  C_CNT_WIDTH  high time in ACLK cycles (slv_reg2)
- int_clr  in  1  single-cycle pulse from a write-1-to-clear of the status register
- pwm_out  out  1  registered PWM output
- irq  out  1  level interrupt, equal to int_pend & ctrl_int_en
- period_end  out  1  one-cycle pulse on the last cycle of each period
- cnt_value  out  C_CNT_WIDTH  current counter, for readback
- status  out  3  {int_ovf, int_pend, running}, for readback

## Operation
- State machine: IDLE, RUN, STOPPING.
- IDLE:
  - cnt=0 and pwm_out=0.
  - If ctrl_en=1 and ctrl_period!=0: load sh_period←ctrl_period and sh_duty←ctrl_duty, set cnt←0, go to RUN.
- RUN:
  - cnt increments by 1 per cycle.
  - When cnt==sh_period-1:
    - period_end=1 in that cycle.
    - Next cycle: cnt←0, sh_period←ctrl_period, sh_duty←ctrl_duty.
  - ctrl_en=0 seen in any RUN cycle → STOPPING. The current period always completes.
- STOPPING:
  - Same counting as RUN, but ctrl_en is ignored.
  - At the period end: period_end pulses, then go to IDLE. No reload occurs.
- Boundary reload with ctrl_period==0: treated as a stop. Go to IDLE with cnt=0 and pwm_out=0. period_end for the final period still pulses.
- pwm_out is registered and equals (cnt < sh_duty) for the cnt and sh_duty values that take effect at the same edge. pwm_out is therefore cycle-aligned with cnt_value.
- Duty boundary cases:
  - sh_duty=0 → pwm_out is constant 0.
  - sh_duty>=sh_period → pwm_out is constant 1 while running.
  - Comparison is unsigned and full width. There is no wrap.
- int_pend:
  - Sticky; set by period_end.
  - Cleared by int_clr.
  - int_clr and period_end in the same cycle → int_pend stays 1 (set wins).
- int_ovf:
  - Sticky; set when period_end occurs while int_pend is already 1.
  - Cleared by int_clr.
  - The same set-wins rule applies.
- running = 1 in RUN and in STOPPING.
- ctrl_int_en gates irq only. The pend and ovf flags update regardless of ctrl_int_en.

## Timing
- Reset values: state=IDLE, cnt_value=0, pwm_out=0, irq=0, period_end=0, status=3'b000, shadows=0.
- ARESET asserted mid-run: all outputs take reset values on the next edge. Pending interrupts are lost.
- Start latency: ctrl_en sampled 1 at edge k → at edge k, cnt=0, running=1, and pwm_out=(ctrl_duty!=0).
- Period is exactly sh_period cycles. High time is exactly min(sh_duty, sh_period) cycles, starting at cnt=0.
- period_end is combinational from registered state and asserted during cnt==sh_period-1.
- int_pend rises on the edge that ends the period_end cycle.
- irq is registered-equivalent: it follows int_pend and ctrl_int_en with no added latency.
- The first pwm_out after reload uses the new sh_duty, so there is no mixed-duty cycle.
- cnt never exceeds sh_period-1.

## Test plan
- Basic PWM: P=10, D=3, en=1.
  - pwm_out is high exactly 3 cycles, then low 7, repeating.
  - period_end pulses every 10 cycles at cnt=9.
- Duty/period update: write D=7 at cnt=5, then P=4 mid-period.
  - The current period stays 3/10.
  - The next period is 4 cycles, fully high (D>=P).
- Duty boundaries:
  - D=0 → pwm_out is never high.
  - D=10 with P=10 → pwm_out stays high.
  - P=1, D=1 → constant high, period_end every cycle.
- Interrupt flags:
  - int_en=1, let 2 periods pass without clearing → irq=1, status=3'b111.
  - int_clr → status=3'b001 and irq=0.
  - int_clr coincident with period_end → int_pend remains 1.
- Stop behaviour, P=10:
  - ctrl_en=0 at cnt=4 → counting continues to cnt=9, period_end pulses, then IDLE with cnt=0 and pwm_out=0.
  - Writing P=0 instead of clearing ctrl_en → same stop at the boundary.
- Reset mid-run: assert ARESET at cnt=6 with int_pend=1 → next edge has all outputs 0.
  - After ARESET deasserts with ctrl_en still 1, restart occurs on the first edge, at cnt=0.
